// File: rtl/ir_temp_pkg.sv
// ----------------------------------------------------------------------------
// ir_temp_pkg
// Shared constants and state types for the IR temperature filter slice.
//   ADC_W            : width of ADC sample / average words
//   *_DEF            : default window depth, alarm thresholds and debounce
//   CNT_W            : width of the alarm debounce counter (DEBOUNCE <= 15)
//   fill_state_t     : window fill control states
//   alarm_state_t    : hysteresis / debounce alarm states
// ----------------------------------------------------------------------------
package ir_temp_pkg;

    localparam int ADC_W         = 12;
    localparam int AVG_LOG2_DEF  = 3;
    localparam int HI_THRESH_DEF = 3000;
    localparam int LO_THRESH_DEF = 2800;
    localparam int DEBOUNCE_DEF  = 4;
    localparam int CNT_W         = 4;

    typedef enum logic {
        FILL,
        RUN
    } fill_state_t;

    typedef enum logic [1:0] {
        COOL,
        ARMING,
        HOT,
        CLEARING
    } alarm_state_t;

endpackage

// File: rtl/ir_temp_filter_alarm.sv
// ----------------------------------------------------------------------------
// ir_temp_alarm
// Over-temperature alarm with hysteresis and debounce. The state advances only
// on cycles where avg_valid is high, using the freshly updated average.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   clear      in   aborts any pending debounce (window flush); alarm holds
//   avg        in   current window average
//   avg_valid  in   avg was updated this cycle
//   alarm      out  registered debounced over-temperature flag
// ----------------------------------------------------------------------------
module ir_temp_alarm
    import ir_temp_pkg::*;
#(
    parameter int ADC_W     = ir_temp_pkg::ADC_W,
    parameter int HI_THRESH = HI_THRESH_DEF,
    parameter int LO_THRESH = LO_THRESH_DEF,
    parameter int DEBOUNCE  = DEBOUNCE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [ADC_W-1:0] avg,
    input  logic             avg_valid,
    output logic             alarm
);

    localparam logic [ADC_W-1:0] HI_C  = ADC_W'(HI_THRESH);
    localparam logic [ADC_W-1:0] LO_C  = ADC_W'(LO_THRESH);
    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE);

    alarm_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             alarm_reg, alarm_next;

    logic             is_hot;
    logic             is_cool;
    logic [CNT_W-1:0] cnt_inc;
    logic             deb_hit;

    assign is_hot  = (avg >= HI_C);
    assign is_cool = (avg <= LO_C);
    assign cnt_inc = cnt_reg + 1'b1;
    // In COOL/HOT the counter sits at 0, so cnt_inc==1 and DEBOUNCE=1 flips
    // the state on the very first qualifying average.
    assign deb_hit = (cnt_inc == DEB_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= COOL;
            cnt_reg   <= '0;
            alarm_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            alarm_reg <= alarm_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (clear) begin
            // Drop back to the settled state the pending run started from.
            cnt_next = '0;
            if (state_reg == ARMING)   state_next = COOL;
            if (state_reg == CLEARING) state_next = HOT;
        end else if (avg_valid) begin
            case (state_reg)
                COOL, ARMING: begin
                    if (is_hot) begin
                        if (deb_hit) begin
                            state_next = HOT;
                            cnt_next   = '0;
                        end else begin
                            state_next = ARMING;
                            cnt_next   = cnt_inc;
                        end
                    end else begin
                        state_next = COOL;
                        cnt_next   = '0;
                    end
                end
                HOT, CLEARING: begin
                    if (is_cool) begin
                        if (deb_hit) begin
                            state_next = COOL;
                            cnt_next   = '0;
                        end else begin
                            state_next = CLEARING;
                            cnt_next   = cnt_inc;
                        end
                    end else begin
                        state_next = HOT;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = COOL;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        alarm_next = (state_next == HOT) || (state_next == CLEARING);
    end

    assign alarm = alarm_reg;

endmodule

// File: rtl/ir_temp_filter.sv
// ----------------------------------------------------------------------------
// ir_temp_filter
// Power-of-two boxcar moving average over raw IR-sensor ADC codes, feeding a
// debounced over-temperature alarm with hysteresis.
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   sample        in   ADC code, taken when sample_valid=1
//   sample_valid  in   one-cycle strobe: new ADC word present
//   flush         in   clears the averaging window (wins over sample_valid)
//   avg           out  current window average (truncated)
//   avg_valid     out  one-cycle pulse: avg was updated
//   filled        out  window holds N samples since reset/flush
//   alarm         out  debounced over-temperature flag
// ----------------------------------------------------------------------------
module ir_temp_filter
    import ir_temp_pkg::*;
#(
    parameter int ADC_W     = ir_temp_pkg::ADC_W,
    parameter int AVG_LOG2  = AVG_LOG2_DEF,
    parameter int HI_THRESH = HI_THRESH_DEF,
    parameter int LO_THRESH = LO_THRESH_DEF,
    parameter int DEBOUNCE  = DEBOUNCE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] sample,
    input  logic             sample_valid,
    input  logic             flush,
    output logic [ADC_W-1:0] avg,
    output logic             avg_valid,
    output logic             filled,
    output logic             alarm
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = ADC_W + AVG_LOG2;

    if (AVG_LOG2 < 1 || AVG_LOG2 > 5) begin : g_bad_avg_log2
        $error("ir_temp_filter: AVG_LOG2 must be in 1..5");
    end
    if (LO_THRESH >= HI_THRESH) begin : g_bad_thresh
        $error("ir_temp_filter: LO_THRESH must be below HI_THRESH");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
        $error("ir_temp_filter: DEBOUNCE must be in 1..15");
    end

    logic                        accept;
    logic [N-1:0][ADC_W-1:0]     buf_q;
    logic [ADC_W-1:0]            oldest;
    logic [AVG_LOG2-1:0]         wr_ptr_reg;
    logic [AVG_LOG2-1:0]         fill_cnt_reg;
    logic [SUM_W-1:0]            sum_reg;
    logic [SUM_W-1:0]            sum_next;
    fill_state_t                 fill_state_reg, fill_state_next;
    logic                        avg_load;
    logic [ADC_W-1:0]            avg_reg;
    logic                        avg_valid_reg;

    // A flush in the same cycle as a strobe drops the sample.
    assign accept = sample_valid && !flush;

    // Window entries: each register only loads when the write pointer selects it.
    for (genvar gi = 0; gi < N; gi++) begin : g_buf
        logic [ADC_W-1:0] entry_reg;
        always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
                entry_reg <= '0;
            end else if (accept && (wr_ptr_reg == AVG_LOG2'(gi))) begin
                entry_reg <= sample;
            end
        end
        assign buf_q[gi] = entry_reg;
    end

    assign oldest = buf_q[wr_ptr_reg];
    // The true result always fits SUM_W bits; any wrap in the intermediate
    // sum+sample cancels out when the evicted entry is subtracted.
    assign sum_next = sum_reg + SUM_W'(sample) - SUM_W'(oldest);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            sum_reg      <= '0;
            wr_ptr_reg   <= '0;
            fill_cnt_reg <= '0;
        end else if (accept) begin
            sum_reg    <= sum_next;
            wr_ptr_reg <= wr_ptr_reg + 1'b1;   // N is a power of two: wraps
            if (fill_state_reg == FILL) begin
                fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
        end
    end

    // Fill control FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            fill_state_reg <= FILL;
        end else begin
            fill_state_reg <= fill_state_next;
        end
    end

    // Fill control FSM: next state
    always_comb begin
        fill_state_next = fill_state_reg;
        case (fill_state_reg)
            FILL:    if (accept && (fill_cnt_reg == AVG_LOG2'(N - 1))) fill_state_next = RUN;
            RUN:     fill_state_next = RUN;
            default: fill_state_next = FILL;
        endcase
    end

    // Fill control FSM: outputs. The sample that completes the window already
    // produces an average.
    always_comb begin
        avg_load = 1'b0;
        case (fill_state_reg)
            FILL:    avg_load = (fill_state_next == RUN);
            RUN:     avg_load = accept;
            default: avg_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            avg_reg       <= '0;
            avg_valid_reg <= 1'b0;
        end else begin
            avg_valid_reg <= avg_load;
            if (avg_load) begin
                avg_reg <= sum_next[SUM_W-1:AVG_LOG2];
            end
        end
    end

    assign avg       = avg_reg;
    assign avg_valid = avg_valid_reg;
    assign filled    = (fill_state_reg == RUN);

    ir_temp_alarm #(
        .ADC_W     (ADC_W),
        .HI_THRESH (HI_THRESH),
        .LO_THRESH (LO_THRESH),
        .DEBOUNCE  (DEBOUNCE)
    ) u_alarm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .avg       (avg_reg),
        .avg_valid (avg_valid_reg),
        .alarm     (alarm)
    );

endmodule

// File: tb/tb_ir_temp_filter.sv
// ----------------------------------------------------------------------------
// tb_ir_temp_filter
// Directed, table-driven bench for ir_temp_filter with default parameters
// (N=8, HI=3000, LO=2800, DEBOUNCE=4). Inputs change on the falling edge and
// outputs are compared on the next falling edge.
// ----------------------------------------------------------------------------
module tb_ir_temp_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sample;
    logic        sample_valid;
    logic        flush;
    logic [11:0] avg;
    logic        avg_valid;
    logic        filled;
    logic        alarm;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ir_temp_filter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .flush        (flush),
        .avg          (avg),
        .avg_valid    (avg_valid),
        .filled       (filled),
        .alarm        (alarm)
    );

    typedef struct {
        logic        valid;
        logic        flsh;
        logic [11:0] smp;
        logic        e_av;
        logic [11:0] e_avg;
        logic        e_filled;
        logic        e_alarm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add_vec(input logic v, input logic f, input int s,
                           input logic eav, input int ea, input logic ef, input logic eal);
        vec_t t;
        t.valid    = v;
        t.flsh     = f;
        t.smp      = 12'(s);
        t.e_av     = eav;
        t.e_avg    = 12'(ea);
        t.e_filled = ef;
        t.e_alarm  = eal;
        vecs.push_back(t);
    endtask

    task automatic check_outputs(input string tag, input logic eav, input int ea,
                                 input logic ef, input logic eal);
        check({tag, ".avg_valid"}, int'(avg_valid), int'(eav));
        check({tag, ".avg"},       int'(avg),       ea);
        check({tag, ".filled"},    int'(filled),    int'(ef));
        check({tag, ".alarm"},     int'(alarm),     int'(eal));
    endtask

    task automatic apply(input vec_t t, input string tag);
        sample_valid = t.valid;
        flush        = t.flsh;
        sample       = t.smp;
        @(negedge clk);
        $display("%s: valid=%0b flush=%0b sample=%0d -> avg_valid=%0b avg=%0d filled=%0b alarm=%0b",
                 tag, t.valid, t.flsh, t.smp, avg_valid, avg, filled, alarm);
        check_outputs(tag, t.e_av, int'(t.e_avg), t.e_filled, t.e_alarm);
    endtask

    task automatic run_range(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            apply(vecs[i], $sformatf("%s[%0d]", tag, i));
        end
        sample_valid = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s1_end;
        int all_end;
        int s1000_avg[8] = '{1917, 1786, 1655, 1524, 1393, 1262, 1131, 1000};
        int s3_smp[6]    = '{3100, 1500, 4095, 3100, 3100, 3100};
        int s3_avg[6]    = '{3100, 2900, 3024, 3024, 3024, 3024};
        int s3_alm[6]    = '{0, 0, 0, 0, 0, 1};
        int s4_smp[6]    = '{2105, 3100, 2300, 1500, 4095, 3100};
        int s4_avg[6]    = '{2900, 2900, 2800, 2800, 2800, 2800};
        int s4_alm[6]    = '{1, 1, 1, 1, 1, 0};
        int s6_avg[10]   = '{950, 1436, 1911, 2373, 2822, 3259, 3683, 4095, 4095, 4095};

        // Scenario 1: 8 samples of 2048, two idle cycles between them.
        for (int i = 0; i < 8; i++) begin
            add_vec(1, 0, 2048, i == 7, (i == 7) ? 2048 : 0, i == 7, 0);
            add_vec(0, 0, 0,    0,      (i == 7) ? 2048 : 0, i == 7, 0);
            add_vec(0, 0, 0,    0,      (i == 7) ? 2048 : 0, i == 7, 0);
        end
        s1_end = vecs.size();
        // Scenario 2: replace window with 1000s back-to-back, then 1008, 1000.
        for (int i = 0; i < 8; i++) add_vec(1, 0, 1000, 1, s1000_avg[i], 1, 0);
        add_vec(1, 0, 1008, 1, 1001, 1, 0);
        add_vec(1, 0, 1000, 1, 1001, 1, 0);
        add_vec(0, 0, 0,    0, 1001, 1, 0);
        // Scenario 3: flush, refill with 3100, interrupted arming run.
        add_vec(0, 1, 0, 0, 1001, 0, 0);
        for (int i = 0; i < 7; i++) add_vec(1, 0, 3100, 0, 1001, 0, 0);
        add_vec(1, 0, 3100, 1, 3100, 1, 0);
        add_vec(0, 0, 0,    0, 3100, 1, 0);
        for (int i = 0; i < 6; i++) begin
            add_vec(1, 0, s3_smp[i], 1, s3_avg[i], 1, 0);
            add_vec(0, 0, 0,         0, s3_avg[i], 1, s3_alm[i] != 0);
        end
        // Scenario 4: in-band averages hold HOT, four at LO_THRESH clear it.
        for (int i = 0; i < 6; i++) begin
            add_vec(1, 0, s4_smp[i], 1, s4_avg[i], 1, 1);
            add_vec(0, 0, 0,         0, s4_avg[i], 1, s4_alm[i] != 0);
        end
        // Scenario 5: flush together with a sample; fresh truncating average.
        add_vec(1, 1, 4095, 0, 2800, 0, 0);
        for (int i = 1; i <= 7; i++) add_vec(1, 0, 100 * i, 0, 2800, 0, 0);
        add_vec(1, 0, 805, 1, 450, 1, 0);
        add_vec(0, 0, 0,   0, 450, 1, 0);
        all_end = vecs.size();

        // Reset from power-up with a strobe present: must be ignored.
        rst_n        = 1'b0;
        flush        = 1'b0;
        sample_valid = 1'b1;
        sample       = 12'd4095;
        repeat (2) @(negedge clk);
        $display("reset: avg_valid=%0b avg=%0d filled=%0b alarm=%0b", avg_valid, avg, filled, alarm);
        check_outputs("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        run_range(0, all_end, "vec");

        // Scenario 6: back-to-back 4095 stream raises the alarm, then reset.
        for (int k = 0; k < 10; k++) begin
            sample_valid = 1'b1;
            sample       = 12'd4095;
            @(negedge clk);
            $display("stream[%0d]: sample=4095 -> avg_valid=%0b avg=%0d filled=%0b alarm=%0b",
                     k, avg_valid, avg, filled, alarm);
            check_outputs($sformatf("stream[%0d]", k), 1, s6_avg[k], 1, k == 9);
        end
        rst_n = 1'b0;
        @(negedge clk);
        $display("midreset: avg_valid=%0b avg=%0d filled=%0b alarm=%0b", avg_valid, avg, filled, alarm);
        check_outputs("midreset", 0, 0, 0, 0);
        rst_n = 1'b1;
        run_range(0, s1_end, "refill");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
